out_frame_buffer: RTL and testbench
===================================

Name: out_frame_buffer

Overview:
- Clocked, parametrised successor to the pixel output memory.
- Captures result words from the datapath into an on-chip frame store. Each accepted word can carry one or several packed pixels.
- Signals frame completion and exposes a synchronous readback port, so the frame can be read without a simulation file dump.
- Sits at the tail of the image-processing pipeline, after the ALU/result stage.

Parameters:
- DATA_W, 8, bits per stored pixel
- WIDTH, 320, pixels per line
- HEIGHT, 240, lines per frame
- RESULT_W, 32, width of the incoming result word
- LANES, 1, pixels packed per accepted word (1, 2 or 4); requires LANES*DATA_W <= RESULT_W and (WIDTH*HEIGHT) % LANES == 0
- CLAMP, 0, 1 = saturate signed lane value into [0, 2^DATA_W-1]; 0 = truncate to low DATA_W bits
- Derived (localparam, not overridable): DEPTH = WIDTH*HEIGHT; ADDR_W = $clog2(DEPTH)

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  arms or restarts frame capture
- in_valid  in  1  result word valid
- in_data  in  RESULT_W  result word; lane i occupies [i*(RESULT_W/LANES) +: RESULT_W/LANES]
- in_ready  out  1  block accepts a word this cycle
- busy  out  1  high while in CAPTURE
- frame_done  out  1  one-cycle pulse when the last pixel is written
- done  out  1  level; high from frame completion until the next start
- restart_err  out  1  one-cycle pulse when start arrives mid-frame
- pix_count  out  ADDR_W+1  pixels written in the current frame
- drop_cnt  out  16  saturating count of in_valid cycles while not ready
- rd_addr  in  ADDR_W  readback pixel address
- rd_data  out  DATA_W  readback data

Behaviour:
- Reset (rst_n=0, asynchronous): state IDLE.
  - Outputs: in_ready=0, busy=0, frame_done=0, done=0, restart_err=0, pix_count=0, drop_cnt=0, rd_data=0.
  - Memory contents are not reset.
- FSM states: IDLE, CAPTURE, DONE.
  - IDLE: start -> CAPTURE, pix_count<=0.
  - CAPTURE: in_ready=1 (combinational from state), busy=1.
  - CAPTURE: a transfer occurs when in_valid && in_ready. It writes LANES pixels to addresses pix_count..pix_count+LANES-1, lane 0 at the lowest address, and then pix_count += LANES.
  - CAPTURE: if the transfer makes pix_count reach DEPTH -> DONE, with frame_done pulsed in the same edge (registered, high for exactly one cycle) and done<=1.
  - DONE: in_ready=0, done=1. start -> CAPTURE, done<=0, pix_count<=0.
- start during CAPTURE:
  - pix_count<=0 and restart_err pulses for one cycle; state stays CAPTURE.
  - If in_valid is also high in that cycle, the word is discarded. Restart has priority over the write.
- start coincident with the final transfer: restart wins; no frame_done pulse, state stays CAPTURE.
- Lane conversion:
  - CLAMP=0: pixel = lane[DATA_W-1:0].
  - CLAMP=1: the lane is treated as signed; negative -> 0; > 2^DATA_W-1 -> 2^DATA_W-1; otherwise unchanged.
- Drops: each cycle with in_valid=1 and in_ready=0 increments drop_cnt, saturating at 16'hFFFF. drop_cnt is cleared only by reset.
- Readback:
  - rd_data <= mem[rd_addr] every cycle, in any state; 1-cycle latency.
  - Same-address read and write in one cycle returns the old data.
  - rd_addr >= DEPTH returns 0.
- Latency: a pixel written at edge N is readable via rd_addr from edge N+1, with data valid after edge N+2.
- Reset mid-frame: immediately returns to IDLE and clears counters. Already-written memory is retained but undefined for a new frame.

Test Plan:
- Bench parameters: WIDTH=4, HEIGHT=2, LANES=1, CLAMP=0. Stimulus: start, then 8 words 0x10..0x17 with continuous valid. Required: in_ready stays high for 8 cycles; frame_done pulses once on the 8th accept; done=1, pix_count=8; readback addr 0..7 returns 0x10..0x17, one cycle after each rd_addr.
- LANES=4, WIDTH=4, HEIGHT=2. Stimulus: start, words 0x03020100 and 0x07060504. Required: mem[0..7]=0x00..0x07; done after the 2nd word; pix_count=8.
- LANES=1, CLAMP=1. Stimulus: words 0xFFFFFFF6 (-10), 0x0000012C (300), 0x0000007F. Required stored values 0x00, 0xFF, 0x7F.
- Start after 3 of 8 words, with in_valid=1 that cycle. Required: restart_err pulses once; pix_count=0; the word is discarded; the next word lands at addr 0.
- Drive in_valid=1 for 5 cycles in IDLE and 3 cycles in DONE. Required: in_ready=0 throughout; drop_cnt=8; memory unchanged.
- Assert rst_n=0 mid-CAPTURE, asynchronously between edges. Required: outputs immediately return to reset values; state IDLE; a subsequent start plus a full frame completes normally.

Source files
------------

// File: rtl/out_frame_buffer.sv
// out_frame_buffer
//   Captures result words from the tail of the image pipeline into an on-chip
//   frame store. Each accepted word carries LANES packed pixels. The block
//   reports when the frame is complete and offers a synchronous readback port.
//
// Ports
//   clk, rst_n    clock; asynchronous active-low reset
//   start         arm a new frame, or restart the frame being captured
//   in_valid      result word valid
//   in_data       result word; lane i at [i*(RESULT_W/LANES) +: RESULT_W/LANES]
//   in_ready      word accepted this cycle (high only while capturing)
//   busy          capture in progress
//   frame_done    one-cycle pulse on the edge that writes the last pixel
//   done          level from frame completion until the next start
//   restart_err   one-cycle pulse when start arrives mid-frame
//   pix_count     pixels written in the current frame
//   drop_cnt      saturating count of in_valid cycles while not ready
//   rd_addr       readback pixel address
//   rd_data       mem[rd_addr], one cycle later; 0 for addresses >= DEPTH
//
// Storage is split into LANES banks. pix_count only ever advances by LANES
// from 0, so pixel address a lives in bank (a % LANES) at row (a / LANES).
// That gives every bank exactly one write port and one read port.

// Per-lane pixel conversion plus the storage bank for that lane.
module out_frame_lane #(
  parameter int DATA_W = 8,
  parameter int LANE_W = 32,
  parameter int CLAMP  = 0,
  parameter int ROWS   = 76800,
  parameter int ROW_W  = 17
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ROW_W-1:0]  wrow,
  input  logic [LANE_W-1:0] lane,
  input  logic [ROW_W-1:0]  rrow,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [ROWS];
  logic [DATA_W-1:0] pix;

  generate
    if (CLAMP != 0) begin : g_clamp
      // Lane is signed: negatives floor at 0, values past the pixel range
      // saturate to all ones.
      localparam logic [LANE_W-1:0] PIX_MAX = LANE_W'({DATA_W{1'b1}});
      always_comb begin
        pix = lane[DATA_W-1:0];
        if (lane[LANE_W-1])
          pix = '0;
        else if (lane > PIX_MAX)
          pix = '1;
      end
    end else begin : g_trunc
      assign pix = lane[DATA_W-1:0];
      if (LANE_W > DATA_W) begin : g_hi
        // Upper lane bits are intentionally dropped when truncating.
        logic unused_hi;
        assign unused_hi = ^lane[LANE_W-1:DATA_W];
      end
    end
  endgenerate

  // Memory is deliberately not reset.
  always_ff @(posedge clk)
    if (we) mem[wrow] <= pix;

  // Asynchronous array read; the top registers it, so a same-cycle write
  // is not visible until the following read (old-data behaviour).
  assign rdata = mem[rrow];

endmodule

module out_frame_buffer #(
  parameter int DATA_W   = 8,
  parameter int WIDTH    = 320,
  parameter int HEIGHT   = 240,
  parameter int RESULT_W = 32,
  parameter int LANES    = 1,
  parameter int CLAMP    = 0,
  localparam int DEPTH   = WIDTH * HEIGHT,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                in_valid,
  input  logic [RESULT_W-1:0] in_data,
  output logic                in_ready,
  output logic                busy,
  output logic                frame_done,
  output logic                done,
  output logic                restart_err,
  output logic [ADDR_W:0]     pix_count,
  output logic [15:0]         drop_cnt,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [DATA_W-1:0]   rd_data
);

  localparam int LANE_W = RESULT_W / LANES;
  localparam int LSH    = $clog2(LANES);
  localparam int ROWS   = DEPTH / LANES;
  localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int LSEL_W = (LANES > 1) ? LSH : 1;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LANES_C = (ADDR_W+1)'(LANES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CAP  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]                    state;
  logic [ADDR_W:0]               pix_next;
  logic                          we;
  logic [ROW_W-1:0]              wrow;
  logic [ROW_W-1:0]              rrow;
  logic [LSEL_W-1:0]             rsel;
  logic [LANES-1:0][DATA_W-1:0]  bank_rd;

  assign in_ready = (state == S_CAP);
  assign busy     = (state == S_CAP);
  assign pix_next = pix_count + LANES_C;

  // Restart has priority: a word presented together with start is dropped.
  assign we   = in_ready && in_valid && !start;
  assign wrow = ROW_W'(pix_count >> LSH);
  assign rrow = ROW_W'(rd_addr >> LSH);

  generate
    if (LANES > 1) begin : g_sel
      assign rsel = rd_addr[LSH-1:0];
    end else begin : g_nosel
      assign rsel = '0;
    end
  endgenerate

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      out_frame_lane #(
        .DATA_W (DATA_W),
        .LANE_W (LANE_W),
        .CLAMP  (CLAMP),
        .ROWS   (ROWS),
        .ROW_W  (ROW_W)
      ) u_lane (
        .clk   (clk),
        .we    (we),
        .wrow  (wrow),
        .lane  (in_data[gi*LANE_W +: LANE_W]),
        .rrow  (rrow),
        .rdata (bank_rd[gi])
      );
    end
  endgenerate

  // Frame capture control.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pix_count   <= '0;
      frame_done  <= 1'b0;
      done        <= 1'b0;
      restart_err <= 1'b0;
    end else begin
      frame_done  <= 1'b0;
      restart_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_CAP;
            pix_count <= '0;
          end
        end
        S_CAP: begin
          if (start) begin
            pix_count   <= '0;
            restart_err <= 1'b1;
          end else if (in_valid) begin
            pix_count <= pix_next;
            if (pix_next == DEPTH_C) begin
              state      <= S_DONE;
              frame_done <= 1'b1;
              done       <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (start) begin
            state     <= S_CAP;
            done      <= 1'b0;
            pix_count <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Words offered while not capturing are lost; count them, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      drop_cnt <= '0;
    else if (in_valid && !in_ready && (drop_cnt != 16'hFFFF))
      drop_cnt <= drop_cnt + 16'd1;
  end

  // Readback runs in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rd_data <= '0;
    else if ({1'b0, rd_addr} < DEPTH_C)
      rd_data <= bank_rd[rsel];
    else
      rd_data <= '0;
  end

endmodule

// File: tb/tb_out_frame_buffer.sv
// Bench for out_frame_buffer: three 4x2 instances (LANES=1 truncating,
// LANES=4 truncating, LANES=1 clamping) checked against a frame-level model.
module tb_out_frame_buffer;

  localparam int NI = 3;
  localparam int DEP = 8;
  localparam int LN [NI] = '{1, 4, 1};
  localparam int CL [NI] = '{0, 0, 1};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start       [NI];
  logic        in_valid    [NI];
  logic [31:0] in_data     [NI];
  logic        in_ready    [NI];
  logic        busy        [NI];
  logic        frame_done  [NI];
  logic        done        [NI];
  logic        restart_err [NI];
  logic [3:0]  pix_count   [NI];
  logic [15:0] drop_cnt    [NI];
  logic [2:0]  rd_addr     [NI];
  logic [7:0]  rd_data     [NI];

  always #5 clk = ~clk;

  out_frame_buffer #(.DATA_W(8), .WIDTH(4), .HEIGHT(2), .RESULT_W(32), .LANES(1), .CLAMP(0)) u_l1 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .in_valid(in_valid[0]), .in_data(in_data[0]),
    .in_ready(in_ready[0]), .busy(busy[0]), .frame_done(frame_done[0]), .done(done[0]),
    .restart_err(restart_err[0]), .pix_count(pix_count[0]), .drop_cnt(drop_cnt[0]),
    .rd_addr(rd_addr[0]), .rd_data(rd_data[0]));

  out_frame_buffer #(.DATA_W(8), .WIDTH(4), .HEIGHT(2), .RESULT_W(32), .LANES(4), .CLAMP(0)) u_l4 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .in_valid(in_valid[1]), .in_data(in_data[1]),
    .in_ready(in_ready[1]), .busy(busy[1]), .frame_done(frame_done[1]), .done(done[1]),
    .restart_err(restart_err[1]), .pix_count(pix_count[1]), .drop_cnt(drop_cnt[1]),
    .rd_addr(rd_addr[1]), .rd_data(rd_data[1]));

  out_frame_buffer #(.DATA_W(8), .WIDTH(4), .HEIGHT(2), .RESULT_W(32), .LANES(1), .CLAMP(1)) u_cl (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .in_valid(in_valid[2]), .in_data(in_data[2]),
    .in_ready(in_ready[2]), .busy(busy[2]), .frame_done(frame_done[2]), .done(done[2]),
    .restart_err(restart_err[2]), .pix_count(pix_count[2]), .drop_cnt(drop_cnt[2]),
    .rd_addr(rd_addr[2]), .rd_data(rd_data[2]));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, act, exp);
  endtask

  // Frame-level model: phase 0 idle, 1 capturing, 2 frame complete.
  int         m_ph   [NI];
  int         m_pix  [NI];
  int         m_drop [NI];
  bit         m_done [NI];
  bit         m_fd   [NI];
  bit         m_re   [NI];
  logic [7:0] m_rd   [NI];
  bit         m_rdk  [NI];
  logic [7:0] m_mem  [NI][DEP];
  bit         m_kn   [NI][DEP];

  function automatic logic [7:0] pixel_of(input int k, input logic [31:0] w, input int i);
    int     lw;
    longint one, v;
    logic [7:0] r;
    lw  = 32 / LN[k];
    one = 1;
    v   = longint'((w >> (i * lw))) & ((one << lw) - 1);
    if (CL[k] == 0) begin
      r = v[7:0];
      return r;
    end
    if (v >= (one << (lw - 1))) v = v - (one << lw);
    if (v < 0) return 8'h00;
    if (v > 255) return 8'hFF;
    r = v[7:0];
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      m_ph[k] = 0; m_pix[k] = 0; m_drop[k] = 0;
      m_done[k] = 0; m_fd[k] = 0; m_re[k] = 0;
      m_rd[k] = 8'h00; m_rdk[k] = 1;
    end
  endtask

  task automatic model_edge(input int k);
    int a;
    a = int'(rd_addr[k]);
    m_rdk[k] = m_kn[k][a];
    m_rd[k]  = m_mem[k][a];
    if (in_valid[k] && m_ph[k] != 1 && m_drop[k] < 65535) m_drop[k]++;
    m_fd[k] = 0;
    m_re[k] = 0;
    if (start[k]) begin
      if (m_ph[k] == 1) m_re[k] = 1;
      m_ph[k] = 1; m_pix[k] = 0; m_done[k] = 0;
    end else if (m_ph[k] == 1 && in_valid[k]) begin
      for (int i = 0; i < LN[k]; i++) begin
        m_mem[k][m_pix[k] + i] = pixel_of(k, in_data[k], i);
        m_kn[k][m_pix[k] + i]  = 1;
      end
      m_pix[k] += LN[k];
      if (m_pix[k] == DEP) begin
        m_ph[k] = 2; m_fd[k] = 1; m_done[k] = 1;
      end
    end
  endtask

  task automatic check_outs(input int k);
    chk($sformatf("ready%0d", k), 32'(in_ready[k]), 32'(m_ph[k] == 1));
    chk($sformatf("busy%0d", k), 32'(busy[k]), 32'(m_ph[k] == 1));
    chk($sformatf("done%0d", k), 32'(done[k]), 32'(m_done[k]));
    chk($sformatf("fdone%0d", k), 32'(frame_done[k]), 32'(m_fd[k]));
    chk($sformatf("rerr%0d", k), 32'(restart_err[k]), 32'(m_re[k]));
    chk($sformatf("pix%0d", k), 32'(pix_count[k]), 32'(m_pix[k]));
    chk($sformatf("drop%0d", k), 32'(drop_cnt[k]), 32'(m_drop[k]));
    if (m_rdk[k]) chk($sformatf("rd%0d", k), 32'(rd_data[k]), 32'(m_rd[k]));
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst_n) model_reset();
    else for (int k = 0; k < NI; k++) model_edge(k);
    #1;
    for (int k = 0; k < NI; k++) check_outs(k);
  endtask

  task automatic idle_all();
    for (int k = 0; k < NI; k++) begin
      start[k] = 0; in_valid[k] = 0; in_data[k] = '0;
    end
  endtask

  task automatic sync_reset();
    idle_all();
    rst_n = 0;
    step();
    step();
    rst_n = 1;
  endtask

  int fd_seen;
  logic [7:0] clamp_exp [3];

  initial begin
    for (int k = 0; k < NI; k++) begin
      rd_addr[k] = '0;
      for (int a = 0; a < DEP; a++) begin
        m_kn[k][a] = 0; m_mem[k][a] = 8'h00;
      end
    end
    model_reset();
    sync_reset();

    // Full frame, one pixel per word, continuous valid.
    start[0] = 1; step(); start[0] = 0;
    fd_seen = 0;
    for (int i = 0; i < 8; i++) begin
      chk("t1_ready", 32'(in_ready[0]), 32'd1);
      in_valid[0] = 1; in_data[0] = 32'h10 + 32'(i);
      step();
      if (frame_done[0]) fd_seen++;
    end
    in_valid[0] = 0;
    chk("t1_fd_count", 32'(fd_seen), 32'd1);
    chk("t1_done", 32'(done[0]), 32'd1);
    chk("t1_pix", 32'(pix_count[0]), 32'd8);
    for (int i = 0; i < 8; i++) begin
      rd_addr[0] = 3'(i); step();
      chk("t1_rdback", 32'(rd_data[0]), 32'h10 + 32'(i));
    end

    // Four pixels per word.
    start[1] = 1; step(); start[1] = 0;
    in_valid[1] = 1; in_data[1] = 32'h03020100; step();
    chk("t2_notdone", 32'(done[1]), 32'd0);
    in_data[1] = 32'h07060504; step();
    in_valid[1] = 0;
    chk("t2_done", 32'(done[1]), 32'd1);
    chk("t2_pix", 32'(pix_count[1]), 32'd8);
    for (int i = 0; i < 8; i++) begin
      rd_addr[1] = 3'(i); step();
      chk("t2_rdback", 32'(rd_data[1]), 32'(i));
    end

    // Clamping of signed lane values.
    clamp_exp[0] = 8'h00; clamp_exp[1] = 8'hFF; clamp_exp[2] = 8'h7F;
    start[2] = 1; step(); start[2] = 0;
    in_valid[2] = 1;
    in_data[2] = 32'hFFFFFFF6; step();
    in_data[2] = 32'h0000012C; step();
    in_data[2] = 32'h0000007F; step();
    in_valid[2] = 0;
    for (int i = 0; i < 3; i++) begin
      rd_addr[2] = 3'(i); step();
      chk("t3_clamp", 32'(rd_data[2]), 32'(clamp_exp[i]));
    end

    // Restart mid-frame with a word presented in the same cycle.
    start[0] = 1; step(); start[0] = 0;
    in_valid[0] = 1;
    for (int i = 0; i < 3; i++) begin
      in_data[0] = 32'h20 + 32'(i); step();
    end
    start[0] = 1; in_data[0] = 32'h99; step();
    chk("t4_rerr", 32'(restart_err[0]), 32'd1);
    chk("t4_pix0", 32'(pix_count[0]), 32'd0);
    start[0] = 0; in_data[0] = 32'hAA; step();
    chk("t4_rerr_once", 32'(restart_err[0]), 32'd0);
    in_valid[0] = 0;
    rd_addr[0] = 3'd0; step();
    chk("t4_addr0", 32'(rd_data[0]), 32'hAA);
    rd_addr[0] = 3'd3; step();
    chk("t4_addr3_old", 32'(rd_data[0]), 32'h13);

    // Drops while idle and after completion.
    sync_reset();
    in_valid[0] = 1; in_data[0] = 32'h55;
    for (int i = 0; i < 5; i++) begin
      chk("t5_idle_ready", 32'(in_ready[0]), 32'd0);
      step();
    end
    in_valid[0] = 0; start[0] = 1; step(); start[0] = 0;
    in_valid[0] = 1;
    for (int i = 0; i < 8; i++) begin
      in_data[0] = 32'h30 + 32'(i); step();
    end
    in_data[0] = 32'hEE;
    for (int i = 0; i < 3; i++) begin
      chk("t5_done_ready", 32'(in_ready[0]), 32'd0);
      step();
    end
    in_valid[0] = 0;
    chk("t5_drops", 32'(drop_cnt[0]), 32'd8);
    for (int i = 0; i < 8; i++) begin
      rd_addr[0] = 3'(i); step();
      chk("t5_mem", 32'(rd_data[0]), 32'h30 + 32'(i));
    end

    // Asynchronous reset in the middle of a capture.
    start[0] = 1; step(); start[0] = 0;
    in_valid[0] = 1;
    for (int i = 0; i < 3; i++) begin
      in_data[0] = 32'h40 + 32'(i); step();
    end
    idle_all();
    #2 rst_n = 0;
    #1;
    chk("t6_ready", 32'(in_ready[0]), 32'd0);
    chk("t6_busy", 32'(busy[0]), 32'd0);
    chk("t6_pix", 32'(pix_count[0]), 32'd0);
    chk("t6_drop", 32'(drop_cnt[0]), 32'd0);
    chk("t6_rd", 32'(rd_data[0]), 32'd0);
    chk("t6_done", 32'(done[1]), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    start[0] = 1; step(); start[0] = 0;
    fd_seen = 0;
    in_valid[0] = 1;
    for (int i = 0; i < 8; i++) begin
      in_data[0] = 32'h50 + 32'(i); step();
      if (frame_done[0]) fd_seen++;
    end
    in_valid[0] = 0;
    chk("t6_fd_count", 32'(fd_seen), 32'd1);
    chk("t6_done_after", 32'(done[0]), 32'd1);

    // Randomized traffic on all instances.
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < NI; k++) begin
        start[k]    = ($urandom_range(0, 19) == 0);
        in_valid[k] = ($urandom_range(0, 3) != 0);
        in_data[k]  = $urandom;
        rd_addr[k]  = 3'($urandom_range(0, 7));
      end
      step();
    end
    idle_all();
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
